// File: rtl/regfile_show_pkg.sv
// Shared constants for the register-file show-port display: active-low {g,f,e,d,c,b,a}
// seven-segment patterns and the scan state encoding.
package regfile_show_pkg;

    typedef enum logic [1:0] {
        StSettle  = 2'd0,
        StCapture = 2'd1,
        StDwell   = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern; shared by display blocks.
module hex_to_seg7
    import regfile_show_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (nibble_i)
            4'h0: seg_o = SEG_HEX_0;
            4'h1: seg_o = SEG_HEX_1;
            4'h2: seg_o = SEG_HEX_2;
            4'h3: seg_o = SEG_HEX_3;
            4'h4: seg_o = SEG_HEX_4;
            4'h5: seg_o = SEG_HEX_5;
            4'h6: seg_o = SEG_HEX_6;
            4'h7: seg_o = SEG_HEX_7;
            4'h8: seg_o = SEG_HEX_8;
            4'h9: seg_o = SEG_HEX_9;
            4'hA: seg_o = SEG_HEX_A;
            4'hB: seg_o = SEG_HEX_B;
            4'hC: seg_o = SEG_HEX_C;
            4'hD: seg_o = SEG_HEX_D;
            4'hE: seg_o = SEG_HEX_E;
            4'hF: seg_o = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/regfile_show_scanner.sv
// Steps the register-file show port through addresses 0..7 and shows each value on a
// multiplexed 4-digit display. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module regfile_show_scanner
    import regfile_show_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES   = 100_000_000,
    parameter int unsigned REFRESH_CYCLES = 100_000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Mode,
    input  logic        Step,
    input  logic [15:0] ShowData,
    output logic [2:0]  ShowAddress,
    output logic [2:0]  AddrLed,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
    localparam int unsigned RefW   = $clog2(REFRESH_CYCLES);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);
    localparam logic [RefW-1:0]   RefLast   = RefW'(REFRESH_CYCLES - 1);

    scan_state_e state_q, state_d;
    logic [2:0]             addr_q, addr_d;
    logic [15:0]            disp_q, disp_d;
    logic [DwellW-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic [SYNC_STAGES-1:0] step_sync_q, mode_sync_q;
    logic                   step_prev_q;
    logic                   step_s, mode_s, step_rise, advance;

    assign step_s    = step_sync_q[SYNC_STAGES-1];
    assign mode_s    = mode_sync_q[SYNC_STAGES-1];
    assign step_rise = step_s & ~step_prev_q;
    // Auto mode ignores Step, so expiry and an edge can never both advance.
    assign advance   = (state_q == StDwell) && (mode_s ? (dwell_cnt_q == DwellLast) : step_rise);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSettle;
            addr_q      <= 3'd0;
            disp_q      <= 16'h0000;
            dwell_cnt_q <= '0;
            step_sync_q <= '0;
            mode_sync_q <= '0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            disp_q      <= disp_d;
            dwell_cnt_q <= dwell_cnt_d;
            step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], Step};
            mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], Mode};
            step_prev_q <= step_s;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSettle:  state_d = StCapture;
            StCapture: state_d = StDwell;
            StDwell:   if (advance) state_d = StSettle;
            default:   state_d = StSettle;
        endcase
    end

    always_comb begin
        addr_d      = advance ? addr_q + 3'd1 : addr_q;
        disp_d      = (state_q == StCapture) ? ShowData : disp_q;
        dwell_cnt_d = '0;
        if (state_q == StDwell && mode_s && !advance) begin
            dwell_cnt_d = dwell_cnt_q + DwellW'(1);
        end
    end

    assign ShowAddress = addr_q;
    assign AddrLed     = addr_q;

    logic [RefW-1:0] ref_q, ref_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d, seg_hex;
    logic            blank;

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (disp_q[{idx_q, 2'b00} +: 4]),
        .seg_o    (seg_hex)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0000);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        ref_d = ref_q + RefW'(1);
        idx_d = idx_q;
        if (ref_q == RefLast) begin
            ref_d = '0;
            idx_d = idx_q + 2'd1;
        end
        // an and seg come from the same idx_q so they switch together without ghosting.
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? SEG_BLANK : seg_hex;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q <= '0;
            idx_q <= 2'd0;
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else begin
            ref_q <= ref_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_regfile_show_scanner.sv
// Directed bench for regfile_show_scanner with short dwell/refresh periods and a small
// register-file model (R3=0019, R7=BEEF). Honours LEADING_ZERO_BLANK_EN for expectations.
module tb_regfile_show_scanner;
    import regfile_show_pkg::*;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SX = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = SX;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic        clk = 1'b0;
    logic        rst, Mode, Step;
    logic [15:0] ShowData;
    logic [2:0]  ShowAddress, AddrLed;
    logic [3:0]  an;
    logic [6:0]  seg;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    regfile_show_scanner #(
        .DWELL_CYCLES   (16),
        .REFRESH_CYCLES (4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Mode        (Mode),
        .Step        (Step),
        .ShowData    (ShowData),
        .ShowAddress (ShowAddress),
        .AddrLed     (AddrLed),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (ShowAddress)
            3'd3:    ShowData = 16'h0019;
            3'd7:    ShowData = 16'hBEEF;
            default: ShowData = 16'h0000;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic tick_to(input int n);
        tick(n - cyc);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Samples one full 16-cycle digit sweep and compares each digit's pattern.
    task automatic sweep(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                         input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] got [4];
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) got[i] = 7'bx;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            case (an)
                4'b1110: got[0] = seg;
                4'b1101: got[1] = seg;
                4'b1011: got[2] = seg;
                4'b0111: got[3] = seg;
                default: bad++;
            endcase
        end
        check({tag, " bad_anodes"}, 16'(bad), 16'd0);
        check({tag, " digit3"}, {9'd0, got[3]}, {9'd0, e3});
        check({tag, " digit2"}, {9'd0, got[2]}, {9'd0, e2});
        check({tag, " digit1"}, {9'd0, got[1]}, {9'd0, e1});
        check({tag, " digit0"}, {9'd0, got[0]}, {9'd0, e0});
    endtask

    initial begin
        rst  = 1'b1;
        Mode = 1'b1;
        Step = 1'b0;
        tick(3);
        check("rst addr", {13'd0, ShowAddress}, 16'd0);
        check("rst led", {13'd0, AddrLed}, 16'd0);
        check("rst an", {12'd0, an}, 16'h000F);
        check("rst seg", {9'd0, seg}, 16'h007F);
        rst = 1'b0;
        cyc = 0;

        tick_to(1);
        check("first an", {12'd0, an}, 16'h000E);
        tick_to(2);
        check("disp after reset", dut.disp_q, 16'h0000);
        check("state dwell", 16'(dut.state_q), 16'(StDwell));
        tick_to(5);
        check("second digit an", {12'd0, an}, 16'h000D);
        sweep("addr0", LZ, LZ, LZ, S0);

        // Auto scan: 18 cycles per register.
        tick_to(53);
        check("auto addr before 3", {13'd0, ShowAddress}, 16'd2);
        tick_to(54);
        check("auto addr 3", {13'd0, ShowAddress}, 16'd3);
        check("auto led 3", {13'd0, AddrLed}, 16'd3);
        tick_to(56);
        check("disp r3", dut.disp_q, 16'h0019);
        sweep("r3", LZ, LZ, S1, S9);
        tick_to(143);
        check("auto addr 7", {13'd0, ShowAddress}, 16'd7);
        tick_to(144);
        check("auto wrap", {13'd0, ShowAddress}, 16'd0);

        // Manual stepping: change lands 3 cycles after the pin rises.
        Mode = 1'b0;
        tick_to(150);
        for (int i = 0; i < 7; i++) begin
            Step = 1'b1;
            tick(2);
            check("step not yet", {13'd0, ShowAddress}, 16'(i));
            tick(1);
            check("step advance", {13'd0, ShowAddress}, 16'(i + 1));
            Step = 1'b0;
            tick(7);
        end
        sweep("r7", SB, SE, SE, SF);

        // Second edge reaches the FSM outside DWELL and must be dropped.
        Step = 1'b1;
        tick(1);
        Step = 1'b0;
        tick(1);
        check("pre wrap", {13'd0, ShowAddress}, 16'd7);
        Step = 1'b1;
        tick(1);
        check("manual wrap", {13'd0, ShowAddress}, 16'd0);
        tick(7);
        check("extra edge dropped", {13'd0, ShowAddress}, 16'd0);
        Step = 1'b0;
        tick(3);

        // Mode switch mid-dwell freezes, then the dwell restarts from 0.
        Mode = 1'b1;
        tick(12);
        check("auto count 10", {12'd0, dut.dwell_cnt_q}, 16'd10);
        Mode = 1'b0;
        tick(120);
        check("manual hold", {13'd0, ShowAddress}, 16'd0);
        check("manual cnt zero", {12'd0, dut.dwell_cnt_q}, 16'd0);
        Mode = 1'b1;
        tick(17);
        check("resume early", {13'd0, ShowAddress}, 16'd0);
        tick(1);
        check("resume advance", {13'd0, ShowAddress}, 16'd1);

        // Reset in the middle of a dwell.
        tick(72);
        check("reach addr 5", {13'd0, ShowAddress}, 16'd5);
        tick(10);
        check("dwell cnt 8", {12'd0, dut.dwell_cnt_q}, 16'd8);
        rst = 1'b1;
        tick(1);
        check("mid rst addr", {13'd0, ShowAddress}, 16'd0);
        check("mid rst an", {12'd0, an}, 16'h000F);
        check("mid rst seg", {9'd0, seg}, 16'h007F);
        check("mid rst state", 16'(dut.state_q), 16'(StSettle));
        rst = 1'b0;
        tick(1);
        check("restart capture", 16'(dut.state_q), 16'(StCapture));
        tick(16);
        check("restart hold", {13'd0, ShowAddress}, 16'd0);
        tick(1);
        check("restart advance", {13'd0, ShowAddress}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
